sram_bus_responder: RTL and testbench
=====================================

Name: sram_bus_responder

Overview:
- Memory-side responder for the 65xx SoC external bus.
- Accepts byte reads and writes, qualified by bus_read/bus_write, from the CPU domain.
- Converts them into word transactions on the 16-bit SRAM controller's request/ready interface, using read-modify-write for byte writes.
- Stalls the CPU through cpu_ready until each access completes.
- Runs on CLK0, three times the CPU clock.

Parameters:
- TIMEOUT_CYCLES, 15: max CLK0 cycles waiting for sram_ready before abort; range 1..255.
- ERR_DATA, 8'hFF: byte returned on bus_di for an aborted read.

Ports:
- CLK0  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- bus_addr  input  19  CPU byte address; [18:1] word address, [0] byte lane.
- bus_do  input  8  CPU write data.
- bus_read  input  1  read strobe, level, active-high.
- bus_write  input  1  write strobe, level, active-high; never asserted together with bus_read.
- bus_di  output  8  read data to CPU.
- cpu_ready  output  1  high = access complete / idle; CPU holds its cycle while low.
- sram_address  output  18  word address to controller.
- sram_data_write  output  16  write word.
- sram_data_read  input  16  read word; valid in the cycle sram_ready=1.
- sram_rd  output  1  one-cycle read request pulse.
- sram_wr  output  1  one-cycle write request pulse.
- sram_ready  input  1  one-cycle completion pulse from controller.
- err  output  1  sticky timeout flag.

Behaviour:
- Reset values: bus_di=0, sram_address=0, sram_data_write=0, sram_rd=0, sram_wr=0, err=0, state=IDLE. cpu_ready is forced 1 while reset_n=0.
- Request key is {bus_write, bus_addr, bus_do}.
- IDLE:
  - On bus_read or bus_write: latch key and go to RD_ISSUE. A write also sets an RMW flag.
- RD_ISSUE: sram_address=latched[18:1], sram_rd=1 for exactly this cycle; go to RD_WAIT.
- RD_WAIT:
  - On sram_ready with RMW flag clear: bus_di = lane 0 ? data[7:0] : data[15:8]. Go to DONE.
  - On sram_ready with RMW flag set: merge bus_do into the selected lane of data, keep the other lane. Drive the result on sram_data_write. Go to WR_ISSUE.
- WR_ISSUE: sram_wr=1 for exactly this cycle; go to WR_WAIT.
- WR_WAIT: on sram_ready go to DONE.
- DONE:
  - Hold bus_di.
  - Return to IDLE when both strobes are low or the key differs from the latched key; a changed key is accepted on the following IDLE cycle.
  - A held identical strobe never retriggers.
- cpu_ready (combinational): 1 in DONE; 1 in IDLE with no strobe; 0 otherwise, including the IDLE cycle where a strobe is first seen.
- Timeout:
  - Counter clears on every ISSUE and increments each cycle in RD_WAIT/WR_WAIT.
  - When it reaches TIMEOUT_CYCLES without sram_ready: set err and go to DONE.
  - An aborted read returns ERR_DATA; an aborted write is dropped.
  - err clears only on reset.
- sram_ready seen outside a WAIT state is ignored.
- Strobe dropping mid-transaction: the transaction still completes to SRAM; DONE then exits on the next cycle.
- Reset mid-transaction: immediate return to IDLE, no further sram_rd/sram_wr pulses.
- Latency with a 1-cycle controller:
  - Read: strobe seen at cycle 0, sram_rd at 1, ready at 2, DONE/cpu_ready=1 at 3.
  - Write: sram_wr at 3, ready at 4, DONE at 5.

Optional Feature:
- Macro: SRAM_RESP_WORD_CACHE_EN.
- Defined: adds a single-entry cache, {valid, word address, 16-bit data}.
  - Updated on every completed SRAM read and every completed write (with the merged word).
  - Read hit in IDLE: bus_di loads from the cache and the state goes directly to DONE, so cpu_ready=1 one cycle after the strobe; no sram_rd.
  - Write hit: merge uses the cached word and goes IDLE→WR_ISSUE, skipping the read phase.
  - valid clears on reset and on any timeout.
- Undefined: no cache; every access issues sram_rd, and every write is a full read-modify-write.

Test Plan:
- Read lane select: SRAM word 0x1234 at word 0x00010 → read bus_addr 0x00020 returns 0x34 and bus_addr 0x00021 returns 0x12. One sram_rd per access; cpu_ready low for 3 cycles with a 1-cycle controller.
- Byte write RMW: word 0xABCD at word 0x3FFFF, write 0x5A to bus_addr 0x7FFFF → sram_data_write=0x5ACD. Exactly one sram_rd then one sram_wr; a subsequent read of 0x7FFFE returns 0xCD.
- Held strobe: hold bus_read on one address for 20 cycles → exactly one sram_rd pulse. Changing bus_addr while the strobe stays high triggers a second access.
- Timeout: sram_ready never asserted, read 0x00100 → after 15 wait cycles err=1, bus_di=0xFF, cpu_ready=1. The next access with a working controller completes normally and err stays 1.
- Reset mid-write: assert reset_n=0 in WR_WAIT → all outputs at reset values and no sram_wr afterwards. Post-reset read succeeds.
- Cache (macro defined): read word 0x00040 twice → second read issues no sram_rd and cpu_ready returns high after 1 cycle. Write to the same word issues sram_wr only, with no sram_rd.

Source files
------------

// File: rtl/sram_bus_responder_if.sv
// CPU-side byte bus between the 65xx core (master) and the SRAM responder (slave).
interface sram_bus_responder_if;
  logic [18:0] bus_addr;
  logic [7:0]  bus_do;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_di;
  logic        cpu_ready;

  modport master (
    output bus_addr, bus_do, bus_read, bus_write,
    input  bus_di, cpu_ready
  );

  modport slave (
    input  bus_addr, bus_do, bus_read, bus_write,
    output bus_di, cpu_ready
  );
endinterface

// File: rtl/sram_bus_responder.sv
// Byte-bus to 16-bit SRAM controller bridge with read-modify-write byte stores and timeout abort.
// Optional single-entry word cache: define SRAM_RESP_WORD_CACHE_EN.
module sram_bus_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [7:0]  ERR_DATA       = 8'hFF
) (
  input  logic                  CLK0,
  input  logic                  reset_n,
  sram_bus_responder_if.slave   bus,
  output logic [17:0]           sram_address,
  output logic [15:0]           sram_data_write,
  input  logic [15:0]           sram_data_read,
  output logic                  sram_rd,
  output logic                  sram_wr,
  input  logic                  sram_ready,
  output logic                  err
);

  localparam int unsigned TMO_W = 8;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE
  } state_t;

  typedef struct packed {
    logic        write;
    logic [18:0] addr;
    logic [7:0]  data;
  } req_key_t;

  state_t             state;
  req_key_t           key_c;
  req_key_t           key_q;
  logic               strobe_c;
  logic               wait_expired_c;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [7:0]         bus_di_q;

`ifdef SRAM_RESP_WORD_CACHE_EN
  logic               cache_valid;
  logic [17:0]        cache_addr;
  logic [15:0]        cache_data;
  logic               cache_hit_c;

  assign cache_hit_c = cache_valid && (cache_addr == bus.bus_addr[18:1]);
`endif

  function automatic logic [7:0] lane_pick(input logic [15:0] word, input logic lane);
    return lane ? word[15:8] : word[7:0];
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] word, input logic lane,
                                             input logic [7:0] byte_in);
    return lane ? {byte_in, word[7:0]} : {word[15:8], byte_in};
  endfunction

  assign strobe_c       = bus.bus_read | bus.bus_write;
  assign key_c          = {bus.bus_write, bus.bus_addr, bus.bus_do};
  assign wait_expired_c = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Stall the CPU from the first strobe cycle until the access reaches DONE.
  assign bus.cpu_ready = !reset_n || (state == DONE) || ((state == IDLE) && !strobe_c);
  assign bus.bus_di    = bus_di_q;

  always_ff @(posedge CLK0) begin
    if (!reset_n) begin
      state           <= IDLE;
      key_q           <= '0;
      bus_di_q        <= '0;
      sram_address    <= '0;
      sram_data_write <= '0;
      sram_rd         <= 1'b0;
      sram_wr         <= 1'b0;
      err             <= 1'b0;
      tmo_cnt         <= '0;
`ifdef SRAM_RESP_WORD_CACHE_EN
      cache_valid     <= 1'b0;
      cache_addr      <= '0;
      cache_data      <= '0;
`endif
    end else begin
      sram_rd <= 1'b0;
      sram_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe_c) begin
            key_q        <= key_c;
            sram_address <= bus.bus_addr[18:1];
`ifdef SRAM_RESP_WORD_CACHE_EN
            if (cache_hit_c && bus.bus_write) begin
              sram_data_write <= lane_merge(cache_data, bus.bus_addr[0], bus.bus_do);
              sram_wr         <= 1'b1;
              state           <= WR_ISSUE;
            end else if (cache_hit_c) begin
              bus_di_q <= lane_pick(cache_data, bus.bus_addr[0]);
              state    <= DONE;
            end else begin
              sram_rd <= 1'b1;
              state   <= RD_ISSUE;
            end
`else
            sram_rd <= 1'b1;
            state   <= RD_ISSUE;
`endif
          end
        end

        RD_ISSUE: begin
          tmo_cnt <= '0;
          state   <= RD_WAIT;
        end

        RD_WAIT: begin
          if (sram_ready) begin
`ifdef SRAM_RESP_WORD_CACHE_EN
            cache_valid <= 1'b1;
            cache_addr  <= sram_address;
            cache_data  <= sram_data_read;
`endif
            // The write flag doubles as the read-modify-write marker.
            if (key_q.write) begin
              sram_data_write <= lane_merge(sram_data_read, key_q.addr[0], key_q.data);
              sram_wr         <= 1'b1;
              state           <= WR_ISSUE;
            end else begin
              bus_di_q <= lane_pick(sram_data_read, key_q.addr[0]);
              state    <= DONE;
            end
          end else if (wait_expired_c) begin
            err <= 1'b1;
            if (!key_q.write) begin
              bus_di_q <= ERR_DATA;
            end
`ifdef SRAM_RESP_WORD_CACHE_EN
            cache_valid <= 1'b0;
`endif
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        WR_ISSUE: begin
          tmo_cnt <= '0;
          state   <= WR_WAIT;
        end

        WR_WAIT: begin
          if (sram_ready) begin
`ifdef SRAM_RESP_WORD_CACHE_EN
            cache_valid <= 1'b1;
            cache_addr  <= sram_address;
            cache_data  <= sram_data_write;
`endif
            state <= DONE;
          end else if (wait_expired_c) begin
            err <= 1'b1;
`ifdef SRAM_RESP_WORD_CACHE_EN
            cache_valid <= 1'b0;
`endif
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        DONE: begin
          // A held identical request stays here; any change re-arms through IDLE.
          if (!strobe_c || (key_c != key_q)) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench for sram_bus_responder with a 1-cycle SRAM controller model.
module tb_sram_bus_responder;

`ifdef SRAM_RESP_WORD_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        CLK0 = 1'b0;
  logic        reset_n;
  logic [17:0] sram_address;
  logic [15:0] sram_data_write;
  logic [15:0] sram_data_read = '0;
  logic        sram_rd;
  logic        sram_wr;
  logic        sram_ready = 1'b0;
  logic        err;

  sram_bus_responder_if bus ();

  sram_bus_responder #(.TIMEOUT_CYCLES(15), .ERR_DATA(8'hFF)) dut (
    .CLK0            (CLK0),
    .reset_n         (reset_n),
    .bus             (bus),
    .sram_address    (sram_address),
    .sram_data_write (sram_data_write),
    .sram_data_read  (sram_data_read),
    .sram_rd         (sram_rd),
    .sram_wr         (sram_wr),
    .sram_ready      (sram_ready),
    .err             (err)
  );

  always #5 CLK0 = ~CLK0;

  logic [15:0] mem [0:262143];
  bit          ctrl_en  = 1'b1;
  bit          wr_block = 1'b0;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  logic [17:0] last_rd_addr = '0;
  logic [17:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  // Controller model: answers a request pulse with ready one cycle later.
  always @(posedge CLK0) begin
    sram_ready <= 1'b0;
    if (sram_rd) begin
      rd_cnt       = rd_cnt + 1;
      last_rd_addr = sram_address;
      if (ctrl_en) begin
        sram_data_read <= mem[sram_address];
        sram_ready     <= 1'b1;
      end
    end
    if (sram_wr) begin
      wr_cnt       = wr_cnt + 1;
      last_wr_addr = sram_address;
      last_wr_data = sram_data_write;
      if (ctrl_en && !wr_block) begin
        mem[sram_address] = sram_data_write;
        sram_ready       <= 1'b1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus_di"}, 32'(bus.bus_di), 32'h0);
    check({tag, "_addr"},   32'(sram_address), 32'h0);
    check({tag, "_wdata"},  32'(sram_data_write), 32'h0);
    check({tag, "_rd"},     32'(sram_rd), 32'h0);
    check({tag, "_wr"},     32'(sram_wr), 32'h0);
    check({tag, "_err"},    32'(err), 32'h0);
    check({tag, "_ready"},  32'(bus.cpu_ready), 32'h1);
  endtask

  // One complete CPU access; starts and ends on a negedge.
  task automatic access(input logic wr, input logic [18:0] addr, input logic [7:0] d,
                        output logic [7:0] rdata, output int lowc);
    bus.bus_addr  = addr;
    bus.bus_do    = d;
    bus.bus_write = wr;
    bus.bus_read  = !wr;
    lowc = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.cpu_ready) break;
      lowc++;
      @(negedge CLK0);
    end
    check("access_completes", 32'(bus.cpu_ready), 32'h1);
    rdata         = bus.bus_di;
    bus.bus_read  = 1'b0;
    bus.bus_write = 1'b0;
    @(negedge CLK0);
    @(negedge CLK0);
  endtask

  logic [7:0] rdata;
  int         lowc;
  int         rd0;
  int         wr0;
  int         wr_snap;
  bit         seen;

  initial begin
    reset_n       = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_do    = '0;
    bus.bus_read  = 1'b0;
    bus.bus_write = 1'b0;
    mem[18'h00010] = 16'h1234;
    mem[18'h3FFFF] = 16'hABCD;
    mem[18'h00100] = 16'hBEEF;
    mem[18'h00101] = 16'h5566;
    mem[18'h00020] = 16'h7788;
    mem[18'h00040] = 16'hC0DE;

    repeat (3) @(negedge CLK0);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge CLK0);

    // Lane select on a read
    rd0 = rd_cnt;
    access(1'b0, 19'h00020, 8'h00, rdata, lowc);
    check("rd_lane0_data", 32'(rdata), 32'h34);
    check("rd_lane0_lowc", 32'(lowc), 32'd3);
    check("rd_lane0_nrd",  32'(rd_cnt - rd0), 32'd1);
    check("rd_lane0_addr", 32'(last_rd_addr), 32'h10);
    rd0 = rd_cnt;
    access(1'b0, 19'h00021, 8'h00, rdata, lowc);
    check("rd_lane1_data", 32'(rdata), 32'h12);
    check("rd_lane1_lowc", 32'(lowc), CACHE ? 32'd1 : 32'd3);
    check("rd_lane1_nrd",  32'(rd_cnt - rd0), CACHE ? 32'd0 : 32'd1);

    // Byte write through read-modify-write at the top word
    rd0 = rd_cnt; wr0 = wr_cnt;
    access(1'b1, 19'h7FFFF, 8'h5A, rdata, lowc);
    check("wr_rmw_wdata", 32'(last_wr_data), 32'h5ACD);
    check("wr_rmw_waddr", 32'(last_wr_addr), 32'h3FFFF);
    check("wr_rmw_nrd",   32'(rd_cnt - rd0), 32'd1);
    check("wr_rmw_nwr",   32'(wr_cnt - wr0), 32'd1);
    check("wr_rmw_lowc",  32'(lowc), 32'd5);
    check("wr_rmw_mem",   32'(mem[18'h3FFFF]), 32'h5ACD);
    access(1'b0, 19'h7FFFE, 8'h00, rdata, lowc);
    check("wr_rmw_readback", 32'(rdata), 32'hCD);

    // Held strobe must not retrigger; an address change must
    rd0 = rd_cnt;
    bus.bus_addr = 19'h00200;
    bus.bus_do   = 8'h00;
    bus.bus_read = 1'b1;
    repeat (20) @(negedge CLK0);
    check("hold_nrd",   32'(rd_cnt - rd0), 32'd1);
    check("hold_ready", 32'(bus.cpu_ready), 32'h1);
    check("hold_data",  32'(bus.bus_di), 32'hEF);
    bus.bus_addr = 19'h00202;
    repeat (10) @(negedge CLK0);
    check("hold_chg_nrd",   32'(rd_cnt - rd0), 32'd2);
    check("hold_chg_data",  32'(bus.bus_di), 32'h66);
    check("hold_chg_ready", 32'(bus.cpu_ready), 32'h1);
    bus.bus_read = 1'b0;
    repeat (2) @(negedge CLK0);

    // Timeout with a dead controller, then recovery with err sticky
    ctrl_en = 1'b0;
    access(1'b0, 19'h00100, 8'h00, rdata, lowc);
    check("tmo_data", 32'(rdata), 32'hFF);
    check("tmo_lowc", 32'(lowc), 32'd17);
    check("tmo_err",  32'(err), 32'h1);
    ctrl_en = 1'b1;
    access(1'b0, 19'h00020, 8'h00, rdata, lowc);
    check("tmo_recover_data", 32'(rdata), 32'h34);
    check("tmo_recover_lowc", 32'(lowc), 32'd3);
    check("tmo_err_sticky",   32'(err), 32'h1);

    // Reset while waiting for the write completion
    wr_block      = 1'b1;
    bus.bus_addr  = 19'h00040;
    bus.bus_do    = 8'h11;
    bus.bus_write = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK0);
      if (sram_wr) begin
        seen = 1'b1;
        break;
      end
    end
    check("rstwr_wr_issued", 32'(seen), 32'h1);
    @(negedge CLK0);
    reset_n       = 1'b0;
    bus.bus_write = 1'b0;
    @(negedge CLK0);
    check_reset_outputs("rstwr");
    wr_snap  = wr_cnt;
    reset_n  = 1'b1;
    wr_block = 1'b0;
    repeat (10) @(negedge CLK0);
    check("rstwr_no_wr",   32'(wr_cnt - wr_snap), 32'd0);
    check("rstwr_mem",     32'(mem[18'h00020]), 32'h7788);
    access(1'b0, 19'h00041, 8'h00, rdata, lowc);
    check("rstwr_post_rd", 32'(rdata), 32'h77);

    // Repeated read and write to one word (cache hits when enabled)
    rd0 = rd_cnt;
    access(1'b0, 19'h00080, 8'h00, rdata, lowc);
    check("c_rd1_data", 32'(rdata), 32'hDE);
    check("c_rd1_nrd",  32'(rd_cnt - rd0), 32'd1);
    rd0 = rd_cnt;
    access(1'b0, 19'h00080, 8'h00, rdata, lowc);
    check("c_rd2_data", 32'(rdata), 32'hDE);
    check("c_rd2_lowc", 32'(lowc), CACHE ? 32'd1 : 32'd3);
    check("c_rd2_nrd",  32'(rd_cnt - rd0), CACHE ? 32'd0 : 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    access(1'b1, 19'h00081, 8'h99, rdata, lowc);
    check("c_wr_nrd",   32'(rd_cnt - rd0), CACHE ? 32'd0 : 32'd1);
    check("c_wr_nwr",   32'(wr_cnt - wr0), 32'd1);
    check("c_wr_lowc",  32'(lowc), CACHE ? 32'd3 : 32'd5);
    check("c_wr_wdata", 32'(last_wr_data), 32'h99DE);
    check("c_wr_mem",   32'(mem[18'h00040]), 32'h99DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
